// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register address width, forwarding select codes
// and the hazard scheduler state encoding.
package cpu_pkg;

    localparam int REG_AW = 3;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FLUSH    = 2'd2,
        MEM_WAIT = 2'd3
    } hz_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline <-> hazard scheduler signal bundle. The pipeline (master) reports
// register usage and events; the scheduler (slave) returns selects and controls.
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = cpu_pkg::REG_AW,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] id_ra;
    logic [REG_AW-1:0] id_rb;
    logic              id_use_ra;
    logic              id_use_rb;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_wr;
    logic              ex_is_load;
    logic [REG_AW-1:0] mem_rd;
    logic              mem_wr;
    logic [REG_AW-1:0] wb_rd;
    logic              wb_wr;
    logic              br_mispredict;
    logic              mem_busy;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              stall_if;
    logic              stall_id;
    logic              stall_ex;
    logic              bubble_ex;
    logic              flush_if;
    logic              flush_id;
    logic              pc_redirect;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output id_ra, id_rb, id_use_ra, id_use_rb, ex_rd, ex_wr, ex_is_load,
               mem_rd, mem_wr, wb_rd, wb_wr, br_mispredict, mem_busy,
        input  fwd_a, fwd_b, stall_if, stall_id, stall_ex, bubble_ex,
               flush_if, flush_id, pc_redirect, stall_cnt
    );

    modport slave (
        input  id_ra, id_rb, id_use_ra, id_use_rb, ex_rd, ex_wr, ex_is_load,
               mem_rd, mem_wr, wb_rd, wb_wr, br_mispredict, mem_busy,
        output fwd_a, fwd_b, stall_if, stall_id, stall_ex, bubble_ex,
               flush_if, flush_id, pc_redirect, stall_cnt
    );

endinterface

// File: rtl/fwd_unit.sv
// Operand forwarding compare for one EX source operand: the youngest
// producing stage wins; a load in EX cannot forward yet.
module fwd_unit
    import cpu_pkg::*;
#(
    parameter int AW = REG_AW
) (
    input  logic [AW-1:0] src,
    input  logic          use_src,
    input  logic [AW-1:0] ex_rd,
    input  logic          ex_wr,
    input  logic          ex_is_load,
    input  logic [AW-1:0] mem_rd,
    input  logic          mem_wr,
    input  logic [AW-1:0] wb_rd,
    input  logic          wb_wr,
    output logic [1:0]    sel
);

    always_comb begin
        sel = FWD_RF;
        if (use_src) begin
            if (ex_wr && !ex_is_load && (ex_rd == src)) begin
                sel = FWD_EX;
            end else if (mem_wr && (mem_rd == src)) begin
                sel = FWD_MEM;
            end else if (wb_wr && (wb_rd == src)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard scheduler: forwarding selects plus prioritised stall, bubble
// and flush control (mem_busy > br_mispredict > load_use) and a stall counter.
module pipe_hazard_ctrl #(
    parameter int REG_AW       = 3,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave hz
);
    import cpu_pkg::*;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    hz_state_t        state_reg, state_next;
    hz_state_t        ret_reg, ret_next;
    hz_state_t        eff_state;
    logic [2:0]       fcnt_reg, fcnt_next;
    logic [CNT_W-1:0] cnt_reg;
    logic             load_use;
    logic [1:0]       fa, fb;
    logic             sif, sid, sex, bub, fif, fid, pcr;

    fwd_unit #(.AW(REG_AW)) u_fwd_a (
        .src(hz.id_ra), .use_src(hz.id_use_ra),
        .ex_rd(hz.ex_rd), .ex_wr(hz.ex_wr), .ex_is_load(hz.ex_is_load),
        .mem_rd(hz.mem_rd), .mem_wr(hz.mem_wr),
        .wb_rd(hz.wb_rd), .wb_wr(hz.wb_wr),
        .sel(fa)
    );

    fwd_unit #(.AW(REG_AW)) u_fwd_b (
        .src(hz.id_rb), .use_src(hz.id_use_rb),
        .ex_rd(hz.ex_rd), .ex_wr(hz.ex_wr), .ex_is_load(hz.ex_is_load),
        .mem_rd(hz.mem_rd), .mem_wr(hz.mem_wr),
        .wb_rd(hz.wb_rd), .wb_wr(hz.wb_wr),
        .sel(fb)
    );

    assign load_use = hz.ex_wr && hz.ex_is_load &&
                      ((hz.id_use_ra && (hz.ex_rd == hz.id_ra)) ||
                       (hz.id_use_rb && (hz.ex_rd == hz.id_rb)));

    always_comb begin
        state_next = state_reg;
        ret_next   = ret_reg;
        fcnt_next  = fcnt_reg;
        sif = 1'b0; sid = 1'b0; sex = 1'b0; bub = 1'b0;
        fif = 1'b0; fid = 1'b0; pcr = 1'b0;
        // Once the wait ends, the saved state acts in that very cycle.
        eff_state = state_reg;
        if (state_reg == MEM_WAIT && !hz.mem_busy) begin
            eff_state = ret_reg;
        end

        if (hz.mem_busy) begin
            sif = 1'b1; sid = 1'b1; sex = 1'b1;
            state_next = MEM_WAIT;
            if (state_reg != MEM_WAIT) begin
                ret_next = (state_reg == FLUSH) ? FLUSH : RUN;
            end
        end else begin
            case (eff_state)
                RUN: begin
                    state_next = RUN;
                    if (hz.br_mispredict) begin
                        fif = 1'b1; fid = 1'b1; pcr = 1'b1;
                        fcnt_next  = FLUSH_LOAD;
                        state_next = (FLUSH_CYCLES == 1) ? RUN : FLUSH;
                    end else if (load_use) begin
                        sif = 1'b1; sid = 1'b1; bub = 1'b1;
                        state_next = LU_STALL;
                    end
                end
                LU_STALL: state_next = RUN;
                FLUSH: begin
                    fif        = 1'b1;
                    fcnt_next  = fcnt_reg - 3'd1;
                    state_next = (fcnt_reg <= 3'd1) ? RUN : FLUSH;
                end
                default: state_next = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= RUN;
            ret_reg   <= RUN;
            fcnt_reg  <= 3'd0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ret_reg   <= ret_next;
            fcnt_reg  <= fcnt_next;
            if (sif && (cnt_reg != {CNT_W{1'b1}})) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    // Outputs are forced low while reset is held, independent of the inputs.
    assign hz.fwd_a       = rst ? FWD_RF : fa;
    assign hz.fwd_b       = rst ? FWD_RF : fb;
    assign hz.stall_if    = sif & ~rst;
    assign hz.stall_id    = sid & ~rst;
    assign hz.stall_ex    = sex & ~rst;
    assign hz.bubble_ex   = bub & ~rst;
    assign hz.flush_if    = fif & ~rst;
    assign hz.flush_id    = fid & ~rst;
    assign hz.pc_redirect = pcr & ~rst;
    assign hz.stall_cnt   = cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed vector table, hand-written
// multi-cycle sequences, and random stimulus against a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int FC = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_AW(3), .CNT_W(16)) hz ();

    pipe_hazard_ctrl #(.REG_AW(3), .FLUSH_CYCLES(FC), .CNT_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .hz (hz)
    );

    typedef struct packed {
        logic [2:0] ra, rb;
        logic       ua, ub;
        logic [2:0] exrd;
        logic       exwr, exld;
        logic [2:0] mrd;
        logic       mwr;
        logic [2:0] wrd;
        logic       wwr, br, busy;
    } in_t;

    typedef struct packed {
        logic [1:0] fa, fb;
        logic       sif, sid, sex, bub, fif, fid, pcr;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Model state: remaining flush cycles, pending load-use recovery cycle, stall count.
    int m_flush_left = 0;
    bit m_after_lu   = 1'b0;
    int m_cnt        = 0;

    function automatic in_t mk_in(input int ra, rb, ua, ub, exrd, exwr, exld,
                                  input int mrd, mwr, wrd, wwr, br, busy);
        in_t v;
        v.ra = 3'(ra); v.rb = 3'(rb); v.ua = 1'(ua); v.ub = 1'(ub);
        v.exrd = 3'(exrd); v.exwr = 1'(exwr); v.exld = 1'(exld);
        v.mrd = 3'(mrd); v.mwr = 1'(mwr); v.wrd = 3'(wrd); v.wwr = 1'(wwr);
        v.br = 1'(br); v.busy = 1'(busy);
        return v;
    endfunction

    function automatic out_t mk_out(input int fa, fb, sif, sid, sex, bub, fif, fid, pcr);
        out_t o;
        o.fa = 2'(fa); o.fb = 2'(fb); o.sif = 1'(sif); o.sid = 1'(sid); o.sex = 1'(sex);
        o.bub = 1'(bub); o.fif = 1'(fif); o.fid = 1'(fid); o.pcr = 1'(pcr);
        return o;
    endfunction

    task automatic apply(input in_t v);
        hz.id_ra = v.ra; hz.id_rb = v.rb; hz.id_use_ra = v.ua; hz.id_use_rb = v.ub;
        hz.ex_rd = v.exrd; hz.ex_wr = v.exwr; hz.ex_is_load = v.exld;
        hz.mem_rd = v.mrd; hz.mem_wr = v.mwr; hz.wb_rd = v.wrd; hz.wb_wr = v.wwr;
        hz.br_mispredict = v.br; hz.mem_busy = v.busy;
    endtask

    function automatic out_t dut_out();
        out_t o;
        o.fa = hz.fwd_a; o.fb = hz.fwd_b; o.sif = hz.stall_if; o.sid = hz.stall_id;
        o.sex = hz.stall_ex; o.bub = hz.bubble_ex; o.fif = hz.flush_if;
        o.fid = hz.flush_id; o.pcr = hz.pc_redirect;
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [2:0] src, input logic u, input in_t v);
        if (!u) return 2'd0;
        if (v.exwr && !v.exld && v.exrd == src) return 2'd1;
        if (v.mwr && v.mrd == src) return 2'd2;
        if (v.wwr && v.wrd == src) return 2'd3;
        return 2'd0;
    endfunction

    function automatic out_t ref_out(input in_t v);
        out_t o;
        bit   lu;
        o  = '0;
        lu = v.exwr && v.exld && ((v.ua && v.exrd == v.ra) || (v.ub && v.exrd == v.rb));
        o.fa = ref_fwd(v.ra, v.ua, v);
        o.fb = ref_fwd(v.rb, v.ub, v);
        if (v.busy) begin
            o.sif = 1'b1; o.sid = 1'b1; o.sex = 1'b1;
        end else if (m_flush_left > 0) begin
            o.fif = 1'b1;
        end else if (m_after_lu) begin
            o.fif = 1'b0;
        end else if (v.br) begin
            o.fif = 1'b1; o.fid = 1'b1; o.pcr = 1'b1;
        end else if (lu) begin
            o.sif = 1'b1; o.sid = 1'b1; o.bub = 1'b1;
        end
        return o;
    endfunction

    task automatic model_step(input in_t v);
        out_t o;
        o = ref_out(v);
        if (o.sif && m_cnt < 65535) m_cnt++;
        if (v.busy)                m_after_lu = 1'b0;
        else if (m_flush_left > 0) m_flush_left--;
        else if (m_after_lu)       m_after_lu = 1'b0;
        else if (v.br)             m_flush_left = FC - 1;
        else if (o.bub)            m_after_lu = 1'b1;
    endtask

    task automatic model_reset();
        m_flush_left = 0;
        m_after_lu   = 1'b0;
        m_cnt        = 0;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        apply('0);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic drive_cycle(input in_t v);
        @(posedge clk);
        #1 apply(v);
        @(negedge clk);
    endtask

    initial begin
        vec_t vecs[8];
        in_t  v;

        vecs[0] = '{mk_in(3,0,1,0, 3,1,0, 3,1, 0,0, 0,0), mk_out(1,0, 0,0,0,0, 0,0,0)};
        vecs[1] = '{mk_in(3,0,1,0, 3,1,1, 3,1, 0,0, 0,0), mk_out(2,0, 1,1,0,1, 0,0,0)};
        vecs[2] = '{mk_in(0,5,0,1, 1,1,0, 2,1, 5,1, 0,0), mk_out(0,3, 0,0,0,0, 0,0,0)};
        vecs[3] = '{mk_in(6,6,0,0, 6,1,0, 6,1, 6,1, 0,0), mk_out(0,0, 0,0,0,0, 0,0,0)};
        vecs[4] = '{mk_in(2,1,1,0, 2,1,1, 0,0, 0,0, 1,0), mk_out(0,0, 0,0,0,0, 1,1,1)};
        vecs[5] = '{mk_in(2,1,1,0, 2,1,1, 0,0, 0,0, 1,1), mk_out(0,0, 1,1,1,0, 0,0,0)};
        vecs[6] = '{mk_in(4,7,1,1, 1,1,0, 4,1, 4,1, 0,0), mk_out(2,0, 0,0,0,0, 0,0,0)};
        vecs[7] = '{mk_in(5,5,1,1, 5,0,0, 0,0, 5,1, 0,0), mk_out(3,3, 0,0,0,0, 0,0,0)};

        // Reset state: outputs forced low even with matching operands applied.
        apply(vecs[0].i);
        #2;
        chk("reset_out", 32'(dut_out()), 32'(out_t'('0)));
        chk("reset_cnt", 32'(hz.stall_cnt), 32'd0);

        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1 rst = 1'b1;
            #1 rst = 1'b0;
            apply(vecs[i].i);
            @(negedge clk);
            chk($sformatf("vec%0d", i), 32'(dut_out()), 32'(vecs[i].o));
        end

        // Load-use: one stall cycle, then MEM forwarding with no stall.
        pulse_reset();
        drive_cycle(mk_in(0,2,0,1, 2,1,1, 0,0, 0,0, 0,0));
        chk("lu_c0", 32'(dut_out()), 32'(mk_out(0,0, 1,1,0,1, 0,0,0)));
        drive_cycle(mk_in(0,2,0,1, 0,0,0, 2,1, 0,0, 0,0));
        chk("lu_c1", 32'(dut_out()), 32'(mk_out(0,2, 0,0,0,0, 0,0,0)));
        chk("lu_cnt", 32'(hz.stall_cnt), 32'd1);

        // Mispredict: redirect+flush, one extra flush_if cycle, then idle.
        pulse_reset();
        drive_cycle(mk_in(0,0,0,0, 0,0,0, 0,0, 0,0, 1,0));
        chk("br_c0", 32'(dut_out()), 32'(mk_out(0,0, 0,0,0,0, 1,1,1)));
        drive_cycle(mk_in(0,0,0,0, 0,0,0, 0,0, 0,0, 0,0));
        chk("br_c1", 32'(dut_out()), 32'(mk_out(0,0, 0,0,0,0, 1,0,0)));
        drive_cycle(mk_in(0,0,0,0, 0,0,0, 0,0, 0,0, 0,0));
        chk("br_c2", 32'(dut_out()), 32'(mk_out(0,0, 0,0,0,0, 0,0,0)));

        // mem_busy for 3 cycles with a held mispredict, serviced in cycle 4.
        pulse_reset();
        for (int c = 0; c < 3; c++) begin
            drive_cycle(mk_in(0,0,0,0, 0,0,0, 0,0, 0,0, 1,1));
            chk($sformatf("wait_c%0d", c), 32'(dut_out()), 32'(mk_out(0,0, 1,1,1,0, 0,0,0)));
        end
        drive_cycle(mk_in(0,0,0,0, 0,0,0, 0,0, 0,0, 1,0));
        chk("wait_c3", 32'(dut_out()), 32'(mk_out(0,0, 0,0,0,0, 1,1,1)));
        chk("wait_cnt", 32'(hz.stall_cnt), 32'd3);

        // Asynchronous reset in the middle of a flush.
        pulse_reset();
        drive_cycle(mk_in(0,2,0,1, 2,1,1, 0,0, 0,0, 0,0));
        drive_cycle(mk_in(0,0,0,0, 0,0,0, 0,0, 0,0, 0,0));
        drive_cycle(mk_in(0,0,0,0, 0,0,0, 0,0, 0,0, 1,0));
        drive_cycle(mk_in(3,0,1,0, 3,1,0, 0,0, 0,0, 0,0));
        chk("arst_pre", 32'(dut_out()), 32'(mk_out(1,0, 0,0,0,0, 1,0,0)));
        #2 rst = 1'b1;
        #1;
        chk("arst_out", 32'(dut_out()), 32'(out_t'('0)));
        chk("arst_cnt", 32'(hz.stall_cnt), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        apply('0);
        @(negedge clk);
        chk("arst_post", 32'(dut_out()), 32'(out_t'('0)));

        // Random stimulus against the behavioural model.
        pulse_reset();
        for (int n = 0; n < 3000; n++) begin
            v      = in_t'($urandom);
            v.ra   = 3'($urandom_range(0, 3));
            v.rb   = 3'($urandom_range(0, 3));
            v.exrd = 3'($urandom_range(0, 3));
            v.mrd  = 3'($urandom_range(0, 3));
            v.wrd  = 3'($urandom_range(0, 3));
            v.busy = ($urandom_range(0, 4) == 0);
            v.br   = ($urandom_range(0, 7) == 0);
            drive_cycle(v);
            chk($sformatf("rnd%0d", n), 32'(dut_out()), 32'(ref_out(v)));
            chk($sformatf("rnd%0d_cnt", n), 32'(hz.stall_cnt), 32'(m_cnt));
            model_step(v);
        end

        // Saturation: a long mem_busy keeps stall_if high past 2^16 cycles.
        pulse_reset();
        drive_cycle(mk_in(0,0,0,0, 0,0,0, 0,0, 0,0, 0,1));
        repeat (65540) @(posedge clk);
        @(negedge clk);
        chk("sat_cnt", 32'(hz.stall_cnt), 32'h0000_FFFF);
        chk("sat_stall", 32'(hz.stall_if), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central hazard scheduler for the 5-stage 16-bit pipelined CPU (IF/ID/EX/MEM/WB, eight registers r0..r7).
- Generates the operand-forwarding selects for the EX stage.
- Generates per-stage stall, bubble and flush controls, resolving load-use, branch-mispredict and data-memory wait hazards with fixed priority.
- Keeps a saturating stall-cycle counter for the top level to expose.

Parameters:
REG_AW, 3, register address width (8 GPRs)
FLUSH_CYCLES, 2, cycles flush_if stays asserted after a mispredict (I-mem latency), range 1..7
CNT_W, 16, stall counter width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
id_ra  in  REG_AW  ID-stage source A register
id_rb  in  REG_AW  ID-stage source B register
id_use_ra  in  1  ID instruction reads A
id_use_rb  in  1  ID instruction reads B
ex_rd  in  REG_AW  EX destination register
ex_wr  in  1  EX instruction writes ex_rd
ex_is_load  in  1  EX instruction is a load
mem_rd  in  REG_AW  MEM destination register
mem_wr  in  1  MEM instruction writes mem_rd
wb_rd  in  REG_AW  WB destination register
wb_wr  in  1  WB instruction writes wb_rd
br_mispredict  in  1  EX resolved a taken/mispredicted branch
mem_busy  in  1  data memory not ready this cycle
fwd_a  out  2  A select: 0 regfile, 1 EX result, 2 MEM result, 3 WB result
fwd_b  out  2  B select, same encoding
stall_if  out  1  hold PC and IF/ID register
stall_id  out  1  hold ID/EX register
stall_ex  out  1  hold EX/MEM register
bubble_ex  out  1  insert NOP into ID/EX
flush_if  out  1  squash IF/ID contents
flush_id  out  1  squash ID/EX contents
pc_redirect  out  1  load PC from branch target
stall_cnt  out  CNT_W  saturating count of cycles with stall_if=1

Behaviour:
- Register-file interface: one clock, clk; reset rst is asynchronous, active-high.
- State register and counters update on posedge clk. All control outputs are combinational from the current state and inputs; no added latency.
- Forwarding (pure combinational), evaluated per operand:
  - EX match (ex_wr && ex_rd==src && !ex_is_load) gives 1.
  - Else MEM match gives 2.
  - Else WB match gives 3.
  - Else 0.
  - Unused operand (id_use_x=0) gives 0.
- load_use = ex_wr && ex_is_load && ((id_use_ra && ex_rd==id_ra) || (id_use_rb && ex_rd==id_rb)).
- FSM states: RUN=0, LU_STALL=1, FLUSH=2, MEM_WAIT=3. Event priority: mem_busy > br_mispredict > load_use.
- RUN:
  - mem_busy: stall_if=stall_id=stall_ex=1; go to MEM_WAIT.
  - Else br_mispredict: flush_if=flush_id=pc_redirect=1; load flush counter with FLUSH_CYCLES-1; go to FLUSH (stay in RUN if FLUSH_CYCLES=1).
  - Else load_use: stall_if=stall_id=1, bubble_ex=1; go to LU_STALL.
- LU_STALL: exactly one bubble has been inserted; no stall output; fwd from MEM resolves the operand. Return to RUN unconditionally. A mem_busy here is handled as in RUN.
- FLUSH: flush_if=1 each cycle; counter decrements; return to RUN when the counter reaches 0. mem_busy preempts: freeze as MEM_WAIT, preserving the counter, then resume FLUSH.
- MEM_WAIT: stall_if=stall_id=stall_ex=1 while mem_busy. When mem_busy falls, return to the saved return state (RUN or FLUSH) in the same edge. A br_mispredict held during the wait is serviced in the first RUN cycle.
- stall_cnt increments on each cycle stall_if=1 and saturates at all-ones (0xFFFF), no wrap.
- Reset: state=RUN, flush counter=0, stall_cnt=0. All outputs are 0 while rst=1, including fwd_a and fwd_b (forced). Reset mid-stall or mid-flush aborts immediately.
- Simultaneous br_mispredict and load_use: the mispredict wins; the load-use instruction is flushed, so no bubble is inserted.

Decomposition:
- Shared package cpu_pkg: fwd select constants (FWD_RF, FWD_EX, FWD_MEM, FWD_WB), FSM state encoding, REG_AW.
- One natural sub-module: fwd_unit, the combinational forwarding compare. Instantiate it twice, once for operand A and once for operand B.

Test Plan:
- ex_wr=1, ex_rd=3, id_ra=3, id_use_ra=1, not load; mem_rd=3 mem_wr=1 -> fwd_a=1 (EX priority), no stall.
- Load r2 in EX, id_rb=2 used -> cycle 0: stall_if=stall_id=bubble_ex=1. Cycle 1: state LU_STALL, outputs 0. With mem_rd=2 -> fwd_b=2. stall_cnt=1.
- br_mispredict=1 for one cycle, FLUSH_CYCLES=2 -> pc_redirect, flush_if and flush_id in cycle 0; flush_if only in cycle 1; RUN in cycle 2.
- mem_busy high 3 cycles with br_mispredict held -> stalls for 3 cycles, stall_cnt=3, then pc_redirect in the 4th cycle.
- Force stall_if for 70000 cycles -> stall_cnt holds 0xFFFF.
- Assert rst asynchronously mid-FLUSH -> all outputs 0 immediately; state RUN after release.
